// File: rtl/mux_src_arbiter_pkg.sv
// Shared definitions for the five-source accumulator mux arbiter and its
// circular priority picker.
package mux_src_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   localparam int unsigned NUM_SRC  = 5;
   localparam logic [2:0]  SEL_IDLE = 3'b111;

   // Modulo-5 add for source indices; both operands are expected in 0..4.
   function automatic logic [2:0] add_mod5(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 4'd5) s = s - 4'd5;
      return s[2:0];
   endfunction

   function automatic logic [4:0] onehot5(input logic [2:0] idx);
      logic [4:0] r;
      r = 5'b00001 << idx;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick5.sv
// Circular priority encoder: first set req bit at or after ptr, wrapping 4->0.
module rr_pick5
   import mux_src_arbiter_pkg::*;
(
   input  logic [4:0] req,
   input  logic [2:0] ptr,
   output logic [2:0] winner,
   output logic       any
);

   logic [2:0] idx;

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      winner = 3'd0;
      any    = 1'b0;
      idx    = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         idx = add_mod5(ptr, 3'(i));
         if (req[idx]) begin
            winner = idx;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_src_arbiter.sv
// Round-robin owner arbiter for the five-source accumulator mux: registered
// one-hot grant and select, hold limit, optional turnaround gap.
module mux_src_arbiter
   import mux_src_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD   = 8,
   parameter bit          TURNAROUND = 1'b1,
   parameter logic [2:0]  IDLE_SEL   = SEL_IDLE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [4:0] req,
   output logic [4:0] gnt,
   output logic [2:0] sel,
   output logic       bus_valid,
   output logic [7:0] owner_cnt,
   output logic [1:0] dbg_state
);

   // Handshake: req is level-held by a source while it wants the bus; the
   // source owns the mux for every cycle gnt shows its bit, including the
   // cycle in which its dropped req is observed and release is decided.

   localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [4:0] gnt_d;
   logic [2:0] sel_d;
   logic [7:0] cnt_d;
   logic [2:0] nxt_ptr, pick_ptr, win;
   logic       any, other, rel;

   // While granting, the only arbitration that matters is the handover one,
   // which must already see the advanced pointer.
   assign nxt_ptr  = add_mod5(sel, 3'd1);
   assign pick_ptr = (state_q == ST_GRANT) ? nxt_ptr : ptr_q;

   rr_pick5 u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .winner (win),
      .any    (any)
   );

   assign other = |(req & ~gnt);
   assign rel   = !req[sel] ||
                  ((MAX_HOLD != 0) && (owner_cnt == HOLD_LAST) && other);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt;
      sel_d   = sel;
      cnt_d   = owner_cnt;
      case (state_q)
         ST_GRANT: begin
            if (rel) begin
               ptr_d = nxt_ptr;
               if (!TURNAROUND && en && any) begin
                  state_d = ST_GRANT;
                  gnt_d   = onehot5(win);
                  sel_d   = win;
                  cnt_d   = 8'd0;
               end else begin
                  state_d = TURNAROUND ? ST_TURN : ST_IDLE;
                  gnt_d   = 5'b0;
                  sel_d   = IDLE_SEL;
                  cnt_d   = 8'd0;
               end
            end else if (owner_cnt != 8'd255) begin
               cnt_d = owner_cnt + 8'd1;
            end
         end
         default: begin
            if (en && any) begin
               state_d = ST_GRANT;
               gnt_d   = onehot5(win);
               sel_d   = win;
               cnt_d   = 8'd0;
            end else begin
               state_d = ST_IDLE;
               gnt_d   = 5'b0;
               sel_d   = IDLE_SEL;
               cnt_d   = 8'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 3'd0;
         gnt       <= 5'b0;
         sel       <= IDLE_SEL;
         bus_valid <= 1'b0;
         owner_cnt <= 8'd0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt       <= gnt_d;
         sel       <= sel_d;
         bus_valid <= |gnt_d;
         owner_cnt <= cnt_d;
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_mux_src_arbiter.sv
// Directed bench for mux_src_arbiter: three parameterisations share one
// stimulus stream; each directed step checks the instance it targets.
module tb_mux_src_arbiter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [4:0] req;

   logic [4:0] gnt_a, gnt_b, gnt_c;
   logic [2:0] sel_a, sel_b, sel_c;
   logic       bv_a, bv_b, bv_c;
   logic [7:0] cnt_a, cnt_b, cnt_c;
   logic [1:0] st_a, st_b, st_c;

   int tests_run = 0;
   int fails     = 0;

   // A: hold limit 2 with turnaround gap
   mux_src_arbiter #(.MAX_HOLD(2), .TURNAROUND(1'b1), .IDLE_SEL(3'b111)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt_a), .sel(sel_a), .bus_valid(bv_a), .owner_cnt(cnt_a), .dbg_state(st_a)
   );

   // B: hold limit 3 with turnaround gap
   mux_src_arbiter #(.MAX_HOLD(3), .TURNAROUND(1'b1), .IDLE_SEL(3'b111)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt_b), .sel(sel_b), .bus_valid(bv_b), .owner_cnt(cnt_b), .dbg_state(st_b)
   );

   // C: default hold limit, back-to-back handover
   mux_src_arbiter #(.MAX_HOLD(8), .TURNAROUND(1'b0), .IDLE_SEL(3'b111)) dut_c (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt_c), .sel(sel_c), .bus_valid(bv_c), .owner_cnt(cnt_c), .dbg_state(st_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      req   = 5'b0;
      en    = 1'b1;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int ph, k;
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 5'b0;

      // Reset state on every instance
      do_reset();
      chk("rst_gnt_a", 8'(gnt_a), 8'h00);
      chk("rst_sel_a", 8'(sel_a), 8'h07);
      chk("rst_bv_a",  8'(bv_a),  8'h00);
      chk("rst_cnt_a", cnt_a,     8'h00);
      chk("rst_st_a",  8'(st_a),  8'h00);
      chk("rst_sel_b", 8'(sel_b), 8'h07);
      chk("rst_sel_c", 8'(sel_c), 8'h07);

      // Reset mid-grant
      req = 5'b00100;
      step();
      chk("mid_gnt_pre", 8'(gnt_a), 8'h04);
      chk("mid_sel_pre", 8'(sel_a), 8'h02);
      chk("mid_bv_pre",  8'(bv_a),  8'h01);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_gnt_async", 8'(gnt_a), 8'h00);
      chk("mid_sel_async", 8'(sel_a), 8'h07);
      chk("mid_bv_async",  8'(bv_a),  8'h00);
      chk("mid_st_async",  8'(st_a),  8'h00);
      #1 rst_n = 1'b1;
      req = 5'b00001;
      step();
      chk("mid_gnt_post", 8'(gnt_a), 8'h01);
      chk("mid_sel_post", 8'(sel_a), 8'h00);

      // Round-robin rotation: two grant cycles then one idle cycle per owner
      do_reset();
      req = 5'b11111;
      for (int i = 0; i < 17; i++) begin
         step();
         ph = i % 3;
         k  = (i / 3) % 5;
         chk($sformatf("rot_sel_%0d", i), 8'(sel_a), (ph == 2) ? 8'h07 : 8'(k));
         chk($sformatf("rot_gnt_%0d", i), 8'(gnt_a), (ph == 2) ? 8'h00 : 8'(1 << k));
         chk($sformatf("rot_cnt_%0d", i), cnt_a, (ph == 1) ? 8'h01 : 8'h00);
      end

      // Voluntary release from source 4 wraps the pointer to 0
      do_reset();
      req = 5'b00010;
      step();
      chk("wrap_sel1", 8'(sel_a), 8'h01);
      req = 5'b10000;
      step();
      chk("wrap_turn1", 8'(sel_a), 8'h07);
      step();
      chk("wrap_sel4", 8'(sel_a), 8'h04);
      req = 5'b00011;
      step();
      chk("wrap_turn2", 8'(sel_a), 8'h07);
      chk("wrap_bv_turn", 8'(bv_a), 8'h00);
      step();
      chk("wrap_sel0", 8'(sel_a), 8'h00);
      chk("wrap_gnt0", 8'(gnt_a), 8'h01);

      // No competitor: hold continues past MAX_HOLD
      do_reset();
      req = 5'b01000;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("solo_gnt_%0d", i), 8'(gnt_b), 8'h08);
         chk($sformatf("solo_sel_%0d", i), 8'(sel_b), 8'h03);
         chk($sformatf("solo_cnt_%0d", i), cnt_b, 8'(i));
      end

      // Enable gating never preempts, only blocks new grants
      do_reset();
      req = 5'b00010;
      step();
      chk("en_gnt1", 8'(gnt_c), 8'h02);
      en  = 1'b0;
      req = 5'b00110;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("en_hold_%0d", i), 8'(gnt_c), 8'h02);
      end
      req = 5'b00100;
      step();
      chk("en_rel_gnt", 8'(gnt_c), 8'h00);
      chk("en_rel_sel", 8'(sel_c), 8'h07);
      chk("en_rel_bv",  8'(bv_c),  8'h00);
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("en_blocked_%0d", i), 8'(gnt_c), 8'h00);
      end
      en = 1'b1;
      step();
      chk("en_gnt2", 8'(gnt_c), 8'h04);
      chk("en_sel2", 8'(sel_c), 8'h02);

      // Back-to-back handover without turnaround
      do_reset();
      req = 5'b00101;
      step();
      chk("b2b_sel0", 8'(sel_c), 8'h00);
      step();
      chk("b2b_cnt1", cnt_c, 8'h01);
      req = 5'b00100;
      step();
      chk("b2b_sel2", 8'(sel_c), 8'h02);
      chk("b2b_gnt2", 8'(gnt_c), 8'h04);
      chk("b2b_bv",   8'(bv_c),  8'h01);
      chk("b2b_cnt0", cnt_c,     8'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
